// File: rtl/m68k_bus_pkg.sv
// Shared types and sizes for the 68000 bus responder and its synchroniser.
package m68k_bus_pkg;

    localparam int SYNC_DEPTH = 3;
    localparam int WAIT_W     = 4;
    localparam int TMO_W      = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT_DS,
        ST_ACCESS,
        ST_DELAY,
        ST_ACK,
        ST_BERR,
        ST_RELEASE
    } bus_state_e;

    // Window compare on word addresses (A23..A1).
    function automatic logic addr_hit(input logic [22:0] a,
                                      input logic [22:0] base,
                                      input logic [22:0] mask);
        return (a & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/m68k_bus_sync.sv
// Three-stage synchroniser for the 7 MHz bus clock and the bus strobes.
// Edge pulses compare stages 1 and 2; the synced levels come from stage 1.
module m68k_bus_sync
    import m68k_bus_pkg::*;
(
    input  logic c200m,
    input  logic reset,
    input  logic c7m_i,
    input  logic as_n_i,
    input  logic uds_n_i,
    input  logic lds_n_i,
    input  logic rw_i,
    output logic c7m_rise_o,
    output logic c7m_fall_o,
    output logic as_n_o,
    output logic uds_n_o,
    output logic lds_n_o,
    output logic rw_o
);

    // bit order: {rw, lds_n, uds_n, as_n, c7m}; strobes idle high, clock low
    localparam logic [4:0] SYNC_IDLE = 5'b11110;

    logic [4:0] stage_q [SYNC_DEPTH];

    // Shift the raw bus signals through the synchroniser chain.
    always_ff @(posedge c200m or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stage_q[i] <= SYNC_IDLE;
            end
        end else begin
            stage_q[0] <= {rw_i, lds_n_i, uds_n_i, as_n_i, c7m_i};
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign c7m_rise_o = !stage_q[2][0] &&  stage_q[1][0];
    assign c7m_fall_o =  stage_q[2][0] && !stage_q[1][0];
    assign as_n_o     = stage_q[1][1];
    assign uds_n_o    = stage_q[1][2];
    assign lds_n_o    = stage_q[1][3];
    assign rw_o       = stage_q[1][4];

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus target: decodes an address window, runs the access on a simple
// backend request/ack port and answers the master with DTACK_n or BERR_n.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | bus free; accept AS_n low once no backend request is open
// DECODE     | one cycle: window compare, latch address and direction
// WAIT_DS    | hit without a data strobe yet; latch lanes and write data
// ACCESS     | mem_req high, waiting for mem_ack or the c7m timeout
// DELAY      | count WAIT_STATES c7m falls, then DTACK on the next rise
// ACK        | DTACK_n low (and data driven on reads) until AS_n rises
// BERR       | BERR_n low until AS_n rises
// RELEASE    | address miss; wait for AS_n to rise without driving
//
// An abort (AS_n high before DTACK) returns straight to IDLE; any open
// backend request stays high there until its ack retires it, and IDLE
// does not take a new cycle until then, so late acks are simply dropped.
module m68k_bus_responder
    import m68k_bus_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR    = 24'hE90000,
    parameter logic [23:0] ADDR_MASK    = 24'hFF0000,
    parameter int          WAIT_STATES  = 0,
    parameter int          BERR_TIMEOUT = 32
) (
    input  logic        c200m,
    input  logic        reset,
    input  logic        M68K_CLK,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    input  logic [22:0] M68K_A,
    input  logic [15:0] M68K_D_in,
    output logic [15:0] M68K_D_out,
    output logic        M68K_D_oe,
    output logic        M68K_DTACK_n,
    output logic        M68K_BERR_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [22:0]       BASE_W   = BASE_ADDR[23:1];
    localparam logic [22:0]       MASK_W   = ADDR_MASK[23:1];
    localparam logic [WAIT_W-1:0] WAIT_LD  = WAIT_W'(WAIT_STATES);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(BERR_TIMEOUT - 1);

    logic c7m_rise, c7m_fall, as_n_s, uds_n_s, lds_n_s, rw_s;
    logic hit, ds_any;

    bus_state_e        state_q, state_d;
    logic              dtack_n_q, dtack_n_d;
    logic              berr_n_q, berr_n_d;
    logic              d_oe_q, d_oe_d;
    logic [15:0]       d_out_q, d_out_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [22:0]       mem_addr_q, mem_addr_d;
    logic [1:0]        mem_be_q, mem_be_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    m68k_bus_sync u_sync (
        .c200m      (c200m),
        .reset      (reset),
        .c7m_i      (M68K_CLK),
        .as_n_i     (M68K_AS_n),
        .uds_n_i    (M68K_UDS_n),
        .lds_n_i    (M68K_LDS_n),
        .rw_i       (M68K_RW),
        .c7m_rise_o (c7m_rise),
        .c7m_fall_o (c7m_fall),
        .as_n_o     (as_n_s),
        .uds_n_o    (uds_n_s),
        .lds_n_o    (lds_n_s),
        .rw_o       (rw_s)
    );

    assign hit    = addr_hit(M68K_A, BASE_W, MASK_W);
    assign ds_any = !(uds_n_s && lds_n_s);

    // Next-state and output decisions for the bus cycle.
    always_comb begin
        state_d     = state_q;
        dtack_n_d   = dtack_n_q;
        berr_n_d    = berr_n_q;
        d_oe_d      = d_oe_q;
        d_out_d     = d_out_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wait_d      = wait_q;
        tmo_d       = tmo_q;

        // an ack always retires the open request, whatever state we are in
        if (mem_req_q && mem_ack) begin
            mem_req_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!as_n_s && !mem_req_q) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (as_n_s) begin
                    state_d = ST_IDLE;
                end else if (!hit) begin
                    state_d = ST_RELEASE;
                end else begin
                    mem_addr_d = M68K_A;
                    mem_we_d   = !rw_s;
                    if (rw_s && ds_any) begin
                        mem_be_d  = {!uds_n_s, !lds_n_s};
                        mem_req_d = 1'b1;
                        tmo_d     = '0;
                        state_d   = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT_DS;
                    end
                end
            end
            ST_WAIT_DS: begin
                if (as_n_s) begin
                    state_d = ST_IDLE;
                end else if (ds_any) begin
                    mem_be_d = {!uds_n_s, !lds_n_s};
                    if (mem_we_q) begin
                        mem_wdata_d = M68K_D_in;
                    end
                    mem_req_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (as_n_s) begin
                    d_oe_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (mem_ack) begin
                    if (!mem_we_q) begin
                        d_out_d = mem_rdata;
                        d_oe_d  = 1'b1;
                    end
                    wait_d  = WAIT_LD;
                    state_d = ST_DELAY;
                end else if (c7m_fall) begin
                    if (tmo_q == TMO_LAST) begin
                        berr_n_d = 1'b0;
                        state_d  = ST_BERR;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                if (as_n_s) begin
                    d_oe_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (wait_q != '0) begin
                    if (c7m_fall) begin
                        wait_d = wait_q - 1'b1;
                    end
                end else if (c7m_rise) begin
                    dtack_n_d = 1'b0;
                    state_d   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (as_n_s) begin
                    dtack_n_d = 1'b1;
                    d_oe_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_BERR: begin
                if (as_n_s) begin
                    berr_n_d = 1'b1;
                    d_oe_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (as_n_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bus-facing registers; reset releases the bus at once.
    always_ff @(posedge c200m or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dtack_n_q   <= 1'b1;
            berr_n_q    <= 1'b1;
            d_oe_q      <= 1'b0;
            d_out_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wait_q      <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            dtack_n_q   <= dtack_n_d;
            berr_n_q    <= berr_n_d;
            d_oe_q      <= d_oe_d;
            d_out_q     <= d_out_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wait_q      <= wait_d;
            tmo_q       <= tmo_d;
        end
    end

    assign M68K_D_out   = d_out_q;
    assign M68K_D_oe    = d_oe_q;
    assign M68K_DTACK_n = dtack_n_q;
    assign M68K_BERR_n  = berr_n_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench: two responders (WAIT_STATES 0 / BERR_TIMEOUT 4 and
// WAIT_STATES 3 / BERR_TIMEOUT 32) share one master-driven bus.
module tb_m68k_bus_responder;

    logic        c200m  = 1'b0;
    logic        reset  = 1'b0;
    logic        c7m    = 1'b0;
    logic        as_n   = 1'b1;
    logic        uds_n  = 1'b1;
    logic        lds_n  = 1'b1;
    logic        rw     = 1'b1;
    logic [22:0] bus_a  = '0;
    logic [15:0] d_in   = '0;
    logic [15:0] rdata  = '0;
    logic        ack_en = 1'b0;

    logic [15:0] d_out0, d_out3, mem_wdata0, mem_wdata3;
    logic        d_oe0, d_oe3, dtack_n0, dtack_n3, berr_n0, berr_n3;
    logic        mem_req0, mem_req3, mem_we0, mem_we3;
    logic [22:0] mem_addr0, mem_addr3;
    logic [1:0]  mem_be0, mem_be3;
    logic        ack0 = 1'b0, ack3 = 1'b0;
    logic [1:0]  cnt0 = '0, cnt3 = '0;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic saw_dtack0, saw_berr0, saw_oe0, saw_req0, saw_dtack3;

    m68k_bus_responder #(.WAIT_STATES(0), .BERR_TIMEOUT(4)) dut0 (
        .c200m(c200m), .reset(reset), .M68K_CLK(c7m), .M68K_AS_n(as_n),
        .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_A(bus_a),
        .M68K_D_in(d_in), .M68K_D_out(d_out0), .M68K_D_oe(d_oe0),
        .M68K_DTACK_n(dtack_n0), .M68K_BERR_n(berr_n0), .mem_req(mem_req0),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_be(mem_be0),
        .mem_wdata(mem_wdata0), .mem_rdata(rdata), .mem_ack(ack0));

    m68k_bus_responder #(.WAIT_STATES(3), .BERR_TIMEOUT(32)) dut3 (
        .c200m(c200m), .reset(reset), .M68K_CLK(c7m), .M68K_AS_n(as_n),
        .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_A(bus_a),
        .M68K_D_in(d_in), .M68K_D_out(d_out3), .M68K_D_oe(d_oe3),
        .M68K_DTACK_n(dtack_n3), .M68K_BERR_n(berr_n3), .mem_req(mem_req3),
        .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_be(mem_be3),
        .mem_wdata(mem_wdata3), .mem_rdata(rdata), .mem_ack(ack3));

    initial forever #5 c200m = ~c200m;
    initial begin
        #2;
        forever #100 c7m = ~c7m;
    end

    // Backend: ack three c200m cycles after the request is seen.
    always @(posedge c200m) begin
        if (ack0) begin
            ack0 <= 1'b0;
            cnt0 <= '0;
        end else if (mem_req0 && ack_en) begin
            if (cnt0 == 2'd2) begin ack0 <= 1'b1; cnt0 <= '0; end
            else cnt0 <= cnt0 + 1'b1;
        end else cnt0 <= '0;
    end

    always @(posedge c200m) begin
        if (ack3) begin
            ack3 <= 1'b0;
            cnt3 <= '0;
        end else if (mem_req3 && ack_en) begin
            if (cnt3 == 2'd2) begin ack3 <= 1'b1; cnt3 <= '0; end
            else cnt3 <= cnt3 + 1'b1;
        end else cnt3 <= '0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_flags();
        saw_dtack0 = 1'b0; saw_berr0 = 1'b0; saw_oe0 = 1'b0;
        saw_req0 = 1'b0; saw_dtack3 = 1'b0;
    endtask

    task automatic watch(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge c200m);
            if (!dtack_n0) saw_dtack0 = 1'b1;
            if (!berr_n0)  saw_berr0  = 1'b1;
            if (d_oe0)     saw_oe0    = 1'b1;
            if (mem_req0)  saw_req0   = 1'b1;
            if (!dtack_n3) saw_dtack3 = 1'b1;
        end
    endtask

    task automatic start_cycle(input logic [23:0] byte_addr, input logic rd,
                               input logic u_n, input logic l_n, input logic [15:0] d);
        @(negedge c7m);
        #1;
        bus_a = byte_addr[23:1];
        rw    = rd;
        d_in  = d;
        as_n  = 1'b0;
        uds_n = u_n;
        lds_n = l_n;
    endtask

    task automatic end_cycle();
        @(negedge c7m);
        #1;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    endtask

    initial begin
        int          rises, falls, r0, r3;
        logic        prev, oe_at, berr_at;
        logic [15:0] dout_at, dout3_at;
        logic [23:0] addr;

        // reset state
        #1 reset = 1'b1;
        #2;
        check("rst_dtack", dtack_n0, 1);
        check("rst_berr", berr_n0, 1);
        check("rst_oe", d_oe0, 0);
        check("rst_dout", d_out0, 0);
        check("rst_req", mem_req0, 0);
        check("rst_addr", mem_addr0, 0);
        #30 reset = 1'b0;

        // read hit: DTACK on first c7m rise (WS=0), three periods later for WS=3
        ack_en = 1'b1;
        rdata  = 16'hBEEF;
        addr   = 24'hE90010;
        start_cycle(addr, 1'b1, 1'b0, 1'b0, 16'h0000);
        rises = 0; r0 = -1; r3 = -1; prev = c7m;
        dout_at = '0; dout3_at = '0; oe_at = 1'b0; berr_at = 1'b0;
        for (int i = 0; i < 400 && (r0 < 0 || r3 < 0); i++) begin
            @(negedge c200m);
            if (c7m && !prev) rises++;
            prev = c7m;
            if (r0 < 0 && !dtack_n0) begin
                r0 = rises; dout_at = d_out0; oe_at = d_oe0; berr_at = berr_n0;
            end
            if (r3 < 0 && !dtack_n3) begin
                r3 = rises; dout3_at = d_out3;
            end
        end
        check("rd_ws0_rises", r0, 1);
        check("rd_ws3_extra", r3 - r0, 3);
        check("rd_dout", dout_at, 16'hBEEF);
        check("rd_oe", oe_at, 1);
        check("rd_berr", berr_at, 1);
        check("rd_dout_ws3", dout3_at, 16'hBEEF);
        check("rd_addr", mem_addr0, addr[23:1]);
        check("rd_be", mem_be0, 2'b11);
        check("rd_we", mem_we0, 0);
        check("rd_req_done", mem_req0, 0);
        end_cycle();
        repeat (2) @(posedge c200m);
        @(negedge c200m);
        check("rd_dtack_held", dtack_n0, 0);
        @(posedge c200m);
        @(negedge c200m);
        check("rel_dtack0", dtack_n0, 1);
        check("rel_oe0", d_oe0, 0);
        check("rel_dtack3", dtack_n3, 1);
        check("rel_oe3", d_oe3, 0);
        watch(40);

        // byte write on the lower lane
        clear_flags();
        addr = 24'hE90022;
        start_cycle(addr, 1'b0, 1'b1, 1'b1, 16'h0055);
        @(posedge c7m);
        #1 lds_n = 1'b0;
        for (int i = 0; i < 400 && (!saw_dtack0 || !saw_dtack3); i++) watch(1);
        check("wr_dtack0", saw_dtack0, 1);
        check("wr_dtack3", saw_dtack3, 1);
        check("wr_we", mem_we0, 1);
        check("wr_addr", mem_addr0, 23'h748011);
        check("wr_be", mem_be0, 2'b01);
        check("wr_wdata", mem_wdata0, 16'h0055);
        check("wr_no_oe", saw_oe0, 0);
        check("wr_we3", mem_we3, 1);
        check("wr_addr3", mem_addr3, addr[23:1]);
        check("wr_be3", mem_be3, 2'b01);
        check("wr_wdata3", mem_wdata3, 16'h0055);
        end_cycle();
        watch(40);

        // address miss
        clear_flags();
        start_cycle(24'hF00000, 1'b1, 1'b0, 1'b0, 16'h0000);
        watch(400);
        check("miss_req", saw_req0, 0);
        check("miss_dtack", saw_dtack0, 0);
        check("miss_berr", saw_berr0, 0);
        check("miss_oe", saw_oe0, 0);
        end_cycle();
        watch(40);

        // timeout: no ack -> BERR after the 4th c7m fall
        ack_en = 1'b0;
        start_cycle(24'hE90100, 1'b1, 1'b0, 1'b0, 16'h0000);
        falls = 0; prev = c7m;
        for (int i = 0; i < 1200 && berr_n0; i++) begin
            @(negedge c200m);
            if (!c7m && prev) falls++;
            prev = c7m;
        end
        check("to_falls", falls, 4);
        check("to_dtack", dtack_n0, 1);
        check("to_req_held", mem_req0, 1);
        watch(60);
        check("to_berr_hold", berr_n0, 0);
        end_cycle();
        repeat (3) @(posedge c200m);
        @(negedge c200m);
        check("to_berr_rel", berr_n0, 1);
        check("to_req_after", mem_req0, 1);
        clear_flags();
        rdata  = 16'h1111;
        ack_en = 1'b1;
        for (int i = 0; i < 100 && (mem_req0 || mem_req3); i++) @(negedge c200m);
        check("to_drain0", mem_req0, 0);
        check("to_drain3", mem_req3, 0);
        watch(40);
        check("to_late_dtack", saw_dtack0, 0);
        check("to_late_oe", saw_oe0, 0);
        check("to_late_dout", d_out0, 16'hBEEF);

        // abort in ACCESS, then a late ack
        ack_en = 1'b0;
        clear_flags();
        start_cycle(24'hE90200, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 100 && !mem_req0; i++) @(negedge c200m);
        check("ab_req", mem_req0, 1);
        @(negedge c200m);
        #1;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        watch(200);
        rdata  = 16'h2222;
        ack_en = 1'b1;
        for (int i = 0; i < 100 && (mem_req0 || mem_req3); i++) watch(1);
        check("ab_drain", mem_req0 | mem_req3, 0);
        watch(40);
        check("ab_dtack0", saw_dtack0, 0);
        check("ab_dtack3", saw_dtack3, 0);
        check("ab_berr", saw_berr0, 0);
        check("ab_oe", saw_oe0, 0);
        check("ab_dout", d_out0, 16'hBEEF);

        // reset pulse while DTACK is asserted
        rdata = 16'h3333;
        start_cycle(24'hE90300, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 400 && dtack_n0; i++) @(negedge c200m);
        check("rs_dtack_on", dtack_n0, 0);
        check("rs_dout_on", d_out0, 16'h3333);
        @(negedge c200m);
        #2;
        reset = 1'b1;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        #1;
        check("rs_dtack", dtack_n0, 1);
        check("rs_oe", d_oe0, 0);
        check("rs_dout", d_out0, 0);
        check("rs_oe3", d_oe3, 0);
        repeat (2) @(posedge c200m);
        #1 reset = 1'b0;
        clear_flags();
        watch(100);
        check("rs_quiet_dtack", saw_dtack0, 0);
        check("rs_quiet_req", saw_req0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
